// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared types and constants for the column-serial approximate multiplier
package approx_mul_pkg;

  // Controller states: waiting for operands, summing columns, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Saturation ceiling for a column count in approximate mode
  localparam int APPROX_CLIP = 3;

  // Carry register width; wide enough for a column count plus the running carry
  function automatic int carry_w(input int width);
    return $clog2(width) + 2;
  endfunction

endpackage

// File: rtl/approx_col_count.sv
// rtl/approx_col_count.sv - popcount of one partial-product column with optional clipping
module approx_col_count
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = carry_w(WIDTH),
  parameter int KW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  input  logic             approx,
  output logic [CW-1:0]    cnt
);

  logic [CW-1:0] w_raw;

  // Count the a[i]&b[j] bits lying on anti-diagonal i+j == k (zero past the top column)
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j == int'(k)) begin
          w_raw = w_raw + CW'(a[i] & b[j]);
        end
      end
    end
  end

  // Saturate the count when this column is approximated
  assign cnt = (approx && (w_raw > CW'(APPROX_CLIP))) ? CW'(APPROX_CLIP) : w_raw;

endmodule

// File: rtl/approx_mul_serial.sv
// rtl/approx_mul_serial.sv - column-serial unsigned multiplier with selectable approximate low columns
module approx_mul_serial
  import approx_mul_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = carry_w(WIDTH);
  localparam int KW = $clog2(2 * WIDTH);
  localparam logic [KW-1:0] LAST_COL = KW'(2 * WIDTH - 1);

  mul_state_t         r_state;
  mul_state_t         w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_approx;
  logic [CW-1:0]      r_carry;
  logic [KW-1:0]      r_k;
  logic [2*WIDTH-1:0] r_p;
  logic               w_col_approx;
  logic [CW-1:0]      w_cnt;
  logic [CW-1:0]      w_sum;

  // Only the low APPROX_COLS columns are clipped, and only when the op asked for it
  assign w_col_approx = r_approx && (int'(r_k) < APPROX_COLS);

  approx_col_count #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .KW    (KW)
  ) u_col_count (
    .a      (r_a),
    .b      (r_b),
    .k      (r_k),
    .approx (w_col_approx),
    .cnt    (w_cnt)
  );

  // Column bits plus the carry rippling up from the previous column
  assign w_sum = w_cnt + r_carry;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept in IDLE, step through every column, hold result until taken
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (r_k == LAST_COL) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch on accept, then one product bit and carry update per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_approx <= 1'b0;
      r_carry  <= '0;
      r_k      <= '0;
      r_p      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_approx <= approx_en;
            r_carry  <= '0;
            r_k      <= '0;
            r_p      <= '0;
          end
        end
        RUN: begin
          r_p[r_k] <= w_sum[0];
          r_carry  <= w_sum >> 1;
          r_k      <= r_k + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign p         = r_p;

endmodule

// File: tb/tb_approx_mul_serial.sv
// tb/tb_approx_mul_serial.sv - randomized self-checking bench for approx_mul_serial
module tb_approx_mul_serial;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv4, ir4, ap4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  logic        iv8, ir8, ap8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_mul_serial #(.WIDTH(4), .APPROX_COLS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .approx_en(ap4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  approx_mul_serial #(.WIDTH(8), .APPROX_COLS(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .approx_en(ap8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact mode is plain a*b; approximate mode does long multiplication
  // column by column with the low columns' bit counts saturated at 3.
  function automatic logic [31:0] model(input int a, input int b, input int apx,
                                        input int w, input int acols);
    int carry;
    int cnt;
    int s;
    logic [31:0] res;
    if (apx == 0 || acols == 0) return a * b;
    carry = 0;
    res   = '0;
    for (int k = 0; k < 2 * w; k++) begin
      cnt = 0;
      for (int i = 0; i < w; i++) begin
        if (k - i >= 0 && k - i < w) cnt += ((a >> i) & 1) * ((b >> (k - i)) & 1);
      end
      if (k < acols && cnt > 3) cnt = 3;
      s      = cnt + carry;
      res[k] = s[0];
      carry  = s / 2;
    end
    return res;
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic apx, input int hold);
    int lat;
    logic [31:0] exp;
    exp = model(a, b, apx, 4, 4);
    @(negedge clk);
    a4 = a; b4 = b; ap4 = apx; iv4 = 1'b1; or4 = (hold == 0);
    check("in_ready_idle", ir4, 1);
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); ap4 = 1'($urandom);
    check("busy_run", busy4, 1);
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency4", lat, 8);
    check("p4", p4, exp);
    check("in_ready_done", ir4, 0);
    for (int h = 0; h < hold; h++) begin
      iv4 = h[0];
      @(posedge clk); #1;
      check("hold_valid", ov4, 1);
      check("hold_p", p4, exp);
      check("hold_in_ready", ir4, 0);
    end
    iv4 = 1'b0; or4 = 1'b1;
    @(posedge clk); #1;
    check("back_idle", ir4, 1);
    check("out_valid_clr", ov4, 0);
    check("p4_kept", p4, exp);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic apx);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; ap8 = apx; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency8", lat, 16);
    check("p8", p8, model(a, b, apx, 8, 0));
    @(posedge clk); #1;
    check("idle8", ir8, 1);
  endtask

  initial begin
    rst = 1'b1;
    iv4 = 0; a4 = 0; b4 = 0; ap4 = 0; or4 = 1;
    iv8 = 0; a8 = 0; b8 = 0; ap8 = 0; or8 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", ir4, 1);
    check("rst_out_valid", ov4, 0);
    check("rst_busy", busy4, 0);
    check("rst_p", p4, 0);
    rst = 1'b0;

    op4(4'd15, 4'd15, 1'b0, 0);
    check("p_15x15_exact", p4, 225);
    op4(4'd15, 4'd15, 1'b1, 0);
    check("p_15x15_approx", p4, 217);
    op4(4'd0, 4'd13, 1'b0, 0);
    op4(4'd0, 4'd13, 1'b1, 0);
    op4(4'd1, 4'd9, 1'b1, 0);
    check("p_1x9_approx", p4, 9);
    op4(4'd11, 4'd14, 1'b1, 5);

    op8(8'd255, 8'd255, 1'b1);
    check("p8_255x255", p8, 65025);

    // reset during column 3 drops the operation
    @(negedge clk);
    a4 = 4'd13; b4 = 4'd11; ap4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_in_ready", ir4, 1);
    check("midrun_out_valid", ov4, 0);
    check("midrun_busy", busy4, 0);
    check("midrun_p", p4, 0);
    op4(4'd6, 4'd7, 1'b0, 0);
    check("p_6x7", p4, 42);

    // reset together with in_valid accepts nothing
    @(negedge clk);
    rst = 1'b1; iv4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    @(posedge clk); #1;
    rst = 1'b0; iv4 = 1'b0;
    check("rst_wins_busy", busy4, 0);
    check("rst_wins_ready", ir4, 1);

    for (int n = 0; n < 24; n++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    for (int n = 0; n < 6; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
